dice_round_ctrl: RTL and testbench
==================================

Name: dice_round_ctrl

Overview:
Parametrised two-dice round controller, successor to the fixed 4-bit turn controller. Accepts validated rolls from the dice generators with a valid strobe and runs a natural/point round: first-roll natural wins, later natural loses, matching the point wins. Adds a roll limit with timeout loss, a face-range check, full-width sum arithmetic, restart on demand, and a reset request to the dice generators. Sits between the dice generators and the score/display logic.

Parameters:
FACE_W, 4, width of each die value
FACE_MAX, 6, largest legal face; legal range is 1..FACE_MAX
NAT_A, 5, first natural sum
NAT_B, 11, second natural sum
MAX_ROLLS, 8, accepted rolls allowed per round, including the first, before timeout; must be >= 2
CNT_W, 4, roll counter width; must hold MAX_ROLLS

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse that begins a new round
roll_valid  in  1  one-cycle strobe; num1/num2 valid this cycle
num1  in  FACE_W  die 1 value
num2  in  FACE_W  die 2 value
win  out  1  round won; held until the next start or reset
lose  out  1  round lost; held until the next start or reset
timeout  out  1  loss caused by the roll limit; held with lose
done  out  1  high in the DONE state
point  out  FACE_W+1  latched point sum
point_valid  out  1  point latched for this round
roll_cnt  out  CNT_W  accepted rolls this round
bad_roll  out  1  one-cycle pulse; roll rejected as out of range
rst_o  out  1  one-cycle pulse requesting dice-generator reset

Behaviour:
- Reset (rst=0, async): state=IDLE. win, lose, timeout, done, point, point_valid, roll_cnt, bad_roll and rst_o are all 0.
- Sum: sum = num1 + num2, computed FACE_W+1 bits wide with no truncation. Natural means sum==NAT_A or sum==NAT_B.
- Legal roll: roll_valid=1 and 1<=num1<=FACE_MAX and 1<=num2<=FACE_MAX.
- Illegal roll with roll_valid=1 in FIRST or POINT:
  - bad_roll pulses 1 the next cycle.
  - The roll is otherwise ignored: no count, no state change.
- roll_valid in IDLE or DONE is ignored, and bad_roll is not asserted.
- All outputs are registered. A result appears the cycle after the sampling edge (1-cycle latency).
- States:
  - IDLE: waits for start. On start -> FIRST; rst_o=1 for one cycle; win, lose, timeout, point, point_valid and roll_cnt are cleared.
  - FIRST, on a legal roll: roll_cnt=1.
    - Natural: win=1 -> DONE.
    - Otherwise: point=sum, point_valid=1 -> POINT.
  - POINT, on a legal roll: roll_cnt+=1.
    - Natural: lose=1 -> DONE. Natural is checked before the point match.
    - Else sum==point: win=1 -> DONE.
    - Else if the new roll_cnt==MAX_ROLLS: lose=1, timeout=1 -> DONE.
    - Else stay in POINT.
  - DONE: done=1; win/lose/point held. On start -> FIRST, with the same clearing and rst_o pulse as from IDLE.
- start in FIRST or POINT aborts the round: same clearing and rst_o pulse, -> FIRST. No win or lose is reported for the aborted round.
- start and roll_valid in the same cycle: start has priority and the roll is discarded (no bad_roll).
- win and lose are never both 1. timeout=1 implies lose=1.
- roll_cnt never exceeds MAX_ROLLS and does not wrap.
- Reset asserted mid-round returns to IDLE immediately. No partial result survives.

Test Plan:
- Reset, start, roll (2,3) -> rst_o pulse after start; next cycle after roll: win=1, done=1, roll_cnt=1, point_valid=0.
- Start, roll (3,4), then (2,3) -> point=7, point_valid=1 after the first roll; lose=1, timeout=0 after the second.
- Start, roll (4,4), then (1,2), then (6,2) -> stays in POINT after (1,2), roll_cnt=2; win=1, point=8, roll_cnt=3 after (6,2).
- Start; first roll (3,4), point=7, then 7 non-natural, non-point rolls of (1,2) with MAX_ROLLS=8 -> after the 8th accepted roll: lose=1, timeout=1, roll_cnt=8.
- FACE_W=4, roll (0,3) then (7,1) in FIRST -> bad_roll pulse for each, roll_cnt stays 0; then roll (6,5) gives sum 11 with no overflow -> win=1.
- Mid-POINT: start together with roll_valid -> roll discarded, state=FIRST, point_valid=0. Then rst=0 mid-round -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dice_round_ctrl_if.sv
// Roll-in / result-out bundle between the dice generators, the round controller and score logic.
// master drives start and rolls; slave (the controller) returns registered round results.
interface dice_round_ctrl_if #(
  parameter int FACE_W = 4,
  parameter int CNT_W  = 4
);
  logic              start;
  logic              roll_valid;
  logic [FACE_W-1:0] num1;
  logic [FACE_W-1:0] num2;
  logic              win;
  logic              lose;
  logic              timeout;
  logic              done;
  logic [FACE_W:0]   point;
  logic              point_valid;
  logic [CNT_W-1:0]  roll_cnt;
  logic              bad_roll;
  logic              rst_o;

  modport master (
    output start, roll_valid, num1, num2,
    input  win, lose, timeout, done, point, point_valid, roll_cnt, bad_roll, rst_o
  );

  modport slave (
    input  start, roll_valid, num1, num2,
    output win, lose, timeout, done, point, point_valid, roll_cnt, bad_roll, rst_o
  );
endinterface

// File: rtl/dice_round_ctrl.sv
// Natural/point dice round controller with roll limit, face-range check and restart.
// All outputs registered, 1-cycle latency; no backpressure, every strobed roll is consumed.
module dice_round_ctrl #(
  parameter int FACE_W    = 4,
  parameter int FACE_MAX  = 6,
  parameter int NAT_A     = 5,
  parameter int NAT_B     = 11,
  parameter int MAX_ROLLS = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  dice_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FIRST, POINT, DONE} state_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic              tmo_q, tmo_d;
  logic              done_q, done_d;
  logic [FACE_W:0]   point_q, point_d;
  logic              pv_q, pv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bad_q, bad_d;
  logic              rsto_q, rsto_d;

  logic [FACE_W:0]   sum;
  logic              legal;
  logic              is_nat;
  logic [CNT_W-1:0]  cnt_inc;

  // Sum is one bit wider than a face so two maximal faces never wrap.
  assign sum     = {1'b0, bus.num1} + {1'b0, bus.num2};
  assign legal   = (bus.num1 != '0) && (bus.num1 <= FACE_W'(FACE_MAX)) &&
                   (bus.num2 != '0) && (bus.num2 <= FACE_W'(FACE_MAX));
  assign is_nat  = (sum == (FACE_W+1)'(NAT_A)) || (sum == (FACE_W+1)'(NAT_B));
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
      point_q <= '0;
      pv_q    <= 1'b0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      rsto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      point_q <= point_d;
      pv_q    <= pv_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      rsto_q  <= rsto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lose_d  = lose_q;
    tmo_d   = tmo_q;
    point_d = point_q;
    pv_d    = pv_q;
    cnt_d   = cnt_q;
    bad_d   = 1'b0;
    rsto_d  = 1'b0;

    // start wins over a same-cycle roll in every state, including abort mid-round.
    if (bus.start) begin
      state_d = FIRST;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      tmo_d   = 1'b0;
      point_d = '0;
      pv_d    = 1'b0;
      cnt_d   = '0;
      rsto_d  = 1'b1;
    end else if (bus.roll_valid && (state_q == FIRST || state_q == POINT)) begin
      if (!legal) begin
        bad_d = 1'b1;
      end else begin
        case (state_q)
          FIRST: begin
            cnt_d = CNT_W'(1);
            if (is_nat) begin
              win_d   = 1'b1;
              state_d = DONE;
            end else begin
              point_d = sum;
              pv_d    = 1'b1;
              state_d = POINT;
            end
          end
          POINT: begin
            cnt_d = cnt_inc;
            if (is_nat) begin
              lose_d  = 1'b1;
              state_d = DONE;
            end else if (sum == point_q) begin
              win_d   = 1'b1;
              state_d = DONE;
            end else if (cnt_inc == CNT_W'(MAX_ROLLS)) begin
              lose_d  = 1'b1;
              tmo_d   = 1'b1;
              state_d = DONE;
            end
          end
          default: ;
        endcase
      end
    end

    done_d = (state_d == DONE);
  end

  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
  assign bus.timeout     = tmo_q;
  assign bus.done        = done_q;
  assign bus.point       = point_q;
  assign bus.point_valid = pv_q;
  assign bus.roll_cnt    = cnt_q;
  assign bus.bad_roll    = bad_q;
  assign bus.rst_o       = rsto_q;

endmodule

// File: tb/tb_dice_round_ctrl.sv
// Directed bench for dice_round_ctrl: one task per scenario, inline checks against hand-computed values.
module tb_dice_round_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dice_round_ctrl_if #(.FACE_W(4), .CNT_W(4)) bus ();

  dice_round_ctrl #(
    .FACE_W(4), .FACE_MAX(6), .NAT_A(5), .NAT_B(11), .MAX_ROLLS(8), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled at that same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_roll(input logic [3:0] a, input logic [3:0] b);
    bus.roll_valid = 1'b1;
    bus.num1       = a;
    bus.num2       = b;
    step();
    bus.roll_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.roll_valid = 1'b0; bus.num1 = '0; bus.num2 = '0;
    step(); step();
    checks++; if ({bus.win, bus.lose, bus.timeout, bus.done} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b expected 0000", {bus.win, bus.lose, bus.timeout, bus.done}); end
    checks++; if ({bus.point, bus.point_valid, bus.roll_cnt, bus.bad_roll, bus.rst_o} !== '0) begin failures++; $display("FAIL reset_data: point=%0d pv=%b cnt=%0d bad=%b rst_o=%b expected all 0", bus.point, bus.point_valid, bus.roll_cnt, bus.bad_roll, bus.rst_o); end
    rst = 1'b1;
    step();
    // Rolls in IDLE (legal or not) are ignored.
    do_roll(4'd2, 4'd3);
    checks++; if ({bus.win, bus.roll_cnt, bus.bad_roll} !== 6'b0) begin failures++; $display("FAIL idle_roll_legal: win=%b cnt=%0d bad=%b expected 0", bus.win, bus.roll_cnt, bus.bad_roll); end
    do_roll(4'd0, 4'd9);
    checks++; if (bus.bad_roll !== 1'b0) begin failures++; $display("FAIL idle_roll_bad: got %b expected 0", bus.bad_roll); end
  endtask

  task automatic test_natural_first();
    do_start();
    checks++; if (bus.rst_o !== 1'b1) begin failures++; $display("FAIL start_rst_o: got %b expected 1", bus.rst_o); end
    checks++; if (bus.roll_cnt !== 4'd0) begin failures++; $display("FAIL start_cnt: got %0d expected 0", bus.roll_cnt); end
    do_roll(4'd2, 4'd3);
    checks++; if (bus.rst_o !== 1'b0) begin failures++; $display("FAIL rst_o_pulse: got %b expected 0", bus.rst_o); end
    checks++; if ({bus.win, bus.lose, bus.done} !== 3'b101) begin failures++; $display("FAIL nat_first_win: win/lose/done=%b expected 101", {bus.win, bus.lose, bus.done}); end
    checks++; if (bus.roll_cnt !== 4'd1 || bus.point_valid !== 1'b0) begin failures++; $display("FAIL nat_first_cnt: cnt=%0d pv=%b expected 1,0", bus.roll_cnt, bus.point_valid); end
    step();
    checks++; if ({bus.win, bus.done} !== 2'b11) begin failures++; $display("FAIL nat_first_hold: win/done=%b expected 11", {bus.win, bus.done}); end
  endtask

  task automatic test_point_lose();
    do_start();
    checks++; if ({bus.win, bus.done} !== 2'b00) begin failures++; $display("FAIL restart_clear: win/done=%b expected 00", {bus.win, bus.done}); end
    do_roll(4'd3, 4'd4);
    checks++; if (bus.point !== 5'd7 || bus.point_valid !== 1'b1) begin failures++; $display("FAIL point_latch: point=%0d pv=%b expected 7,1", bus.point, bus.point_valid); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL point_not_done: got %b expected 0", bus.done); end
    do_roll(4'd2, 4'd3);
    checks++; if ({bus.win, bus.lose, bus.timeout, bus.done} !== 4'b0101) begin failures++; $display("FAIL later_nat_lose: w/l/t/d=%b expected 0101", {bus.win, bus.lose, bus.timeout, bus.done}); end
  endtask

  task automatic test_point_win();
    do_start();
    do_roll(4'd4, 4'd4);
    do_roll(4'd1, 4'd2);
    checks++; if (bus.roll_cnt !== 4'd2 || bus.done !== 1'b0 || bus.point !== 5'd8) begin failures++; $display("FAIL point_stay: cnt=%0d done=%b point=%0d expected 2,0,8", bus.roll_cnt, bus.done, bus.point); end
    do_roll(4'd6, 4'd2);
    checks++; if ({bus.win, bus.lose, bus.done} !== 3'b101) begin failures++; $display("FAIL point_match_win: w/l/d=%b expected 101", {bus.win, bus.lose, bus.done}); end
    checks++; if (bus.point !== 5'd8 || bus.roll_cnt !== 4'd3) begin failures++; $display("FAIL point_match_vals: point=%0d cnt=%0d expected 8,3", bus.point, bus.roll_cnt); end
  endtask

  task automatic test_timeout();
    do_start();
    do_roll(4'd3, 4'd4);
    for (int i = 0; i < 6; i++) do_roll(4'd1, 4'd2);
    checks++; if (bus.roll_cnt !== 4'd7 || bus.done !== 1'b0) begin failures++; $display("FAIL pre_timeout: cnt=%0d done=%b expected 7,0", bus.roll_cnt, bus.done); end
    do_roll(4'd1, 4'd2);
    checks++; if ({bus.win, bus.lose, bus.timeout, bus.done} !== 4'b0111) begin failures++; $display("FAIL timeout_flags: w/l/t/d=%b expected 0111", {bus.win, bus.lose, bus.timeout, bus.done}); end
    checks++; if (bus.roll_cnt !== 4'd8) begin failures++; $display("FAIL timeout_cnt: got %0d expected 8", bus.roll_cnt); end
    do_roll(4'd1, 4'd2);
    checks++; if (bus.roll_cnt !== 4'd8 || bus.timeout !== 1'b1) begin failures++; $display("FAIL done_roll_ignored: cnt=%0d t=%b expected 8,1", bus.roll_cnt, bus.timeout); end
  endtask

  task automatic test_bad_roll();
    do_start();
    do_roll(4'd0, 4'd3);
    checks++; if (bus.bad_roll !== 1'b1 || bus.roll_cnt !== 4'd0) begin failures++; $display("FAIL bad_zero: bad=%b cnt=%0d expected 1,0", bus.bad_roll, bus.roll_cnt); end
    step();
    checks++; if (bus.bad_roll !== 1'b0) begin failures++; $display("FAIL bad_pulse: got %b expected 0", bus.bad_roll); end
    do_roll(4'd7, 4'd1);
    checks++; if (bus.bad_roll !== 1'b1 || bus.roll_cnt !== 4'd0 || bus.point_valid !== 1'b0) begin failures++; $display("FAIL bad_high: bad=%b cnt=%0d pv=%b expected 1,0,0", bus.bad_roll, bus.roll_cnt, bus.point_valid); end
    do_roll(4'd6, 4'd5);
    checks++; if ({bus.win, bus.done, bus.bad_roll} !== 3'b110 || bus.roll_cnt !== 4'd1) begin failures++; $display("FAIL sum11_win: w/d/bad=%b cnt=%0d expected 110,1", {bus.win, bus.done, bus.bad_roll}, bus.roll_cnt); end
    do_roll(4'd0, 4'd0);
    checks++; if (bus.bad_roll !== 1'b0 || bus.win !== 1'b1) begin failures++; $display("FAIL done_bad_ignored: bad=%b win=%b expected 0,1", bus.bad_roll, bus.win); end
  endtask

  task automatic test_abort_and_async_reset();
    do_start();
    do_roll(4'd4, 4'd4);
    bus.start = 1'b1;
    bus.roll_valid = 1'b1; bus.num1 = 4'd4; bus.num2 = 4'd4;
    step();
    bus.start = 1'b0; bus.roll_valid = 1'b0;
    checks++; if ({bus.point_valid, bus.win, bus.lose, bus.bad_roll, bus.rst_o} !== 5'b00001) begin failures++; $display("FAIL abort_flags: pv/w/l/bad/rst_o=%b expected 00001", {bus.point_valid, bus.win, bus.lose, bus.bad_roll, bus.rst_o}); end
    checks++; if (bus.roll_cnt !== 4'd0 || bus.point !== 5'd0) begin failures++; $display("FAIL abort_clear: cnt=%0d point=%0d expected 0,0", bus.roll_cnt, bus.point); end
    do_roll(4'd3, 4'd3);
    checks++; if (bus.point !== 5'd6 || bus.point_valid !== 1'b1 || bus.roll_cnt !== 4'd1) begin failures++; $display("FAIL abort_in_first: point=%0d pv=%b cnt=%0d expected 6,1,1", bus.point, bus.point_valid, bus.roll_cnt); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.point, bus.point_valid, bus.roll_cnt, bus.win, bus.lose, bus.timeout, bus.done, bus.bad_roll, bus.rst_o} !== '0) begin failures++; $display("FAIL async_reset: point=%0d pv=%b cnt=%0d expected all 0", bus.point, bus.point_valid, bus.roll_cnt); end
    step();
    rst = 1'b1;
    do_roll(4'd2, 4'd3);
    checks++; if (bus.win !== 1'b0 || bus.roll_cnt !== 4'd0) begin failures++; $display("FAIL reset_to_idle: win=%b cnt=%0d expected 0,0", bus.win, bus.roll_cnt); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_natural_first();
    test_point_lose();
    test_point_win();
    test_timeout();
    test_bad_roll();
    test_abort_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
